// File: rtl/step_dir_conditioner.sv
// rtl/step_dir_conditioner.sv - STEP/DIR pin conditioner: sync, glitch filter, step pulse, setup check
// Optional signed position counter and port under `STEPDIR_POSITION_EN.

module sdc_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic toggle_o
);
  localparam logic [7:0] LEN_M1 = 8'(FILTER_LEN - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Mismatch run length; the level flips on the FILTER_LEN-th consecutive mismatch.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LEN_M1) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o  = level_q;
  assign toggle_o = (level_d != level_q);
endmodule

module step_dir_conditioner #(
  parameter int FILTER_LEN = 4,
  parameter int DIR_SETUP  = 2,
  parameter int POS_WIDTH  = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        step_in_i,
  input  logic                        dir_in_i,
  input  logic                        err_clear_i,
  output logic                        step_pulse_o,
  output logic                        dir_out_o,
  output logic                        setup_err_o
`ifdef STEPDIR_POSITION_EN
  ,
  output logic signed [POS_WIDTH-1:0] position_o
`endif
);
  localparam logic [7:0] SETUP_C = 8'(DIR_SETUP);

  logic       step_level;
  logic       step_toggle;
  logic       dir_level;
  logic       dir_toggle;

  logic       rise_q;
  logic       pulse_q;
  logic       pulse_d;
  logic       dir_out_q;
  logic       dir_out_d;
  logic       err_q;
  logic       err_d;
  logic [7:0] stable_q;
  logic [7:0] stable_d;

  sdc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .async_i  (step_in_i),
    .level_o  (step_level),
    .toggle_o (step_toggle)
  );

  sdc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .async_i  (dir_in_i),
    .level_o  (dir_level),
    .toggle_o (dir_toggle)
  );

  // rise_q marks the cycle after the filtered step went high; enable is judged only then,
  // so a rise seen while disabled is dropped rather than held over.
  always_comb begin
    pulse_d   = enable_i & rise_q;
    dir_out_d = pulse_d ? dir_level : dir_out_q;
    stable_d  = stable_q;
    if (dir_toggle) begin
      stable_d = '0;
    end else if (stable_q < SETUP_C) begin
      stable_d = stable_q + 8'd1;
    end
    err_d = err_q;
    if (pulse_d && (stable_q < SETUP_C)) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rise_q    <= 1'b0;
      pulse_q   <= 1'b0;
      dir_out_q <= 1'b0;
      err_q     <= 1'b0;
      stable_q  <= SETUP_C;
    end else begin
      rise_q    <= step_toggle & ~step_level;
      pulse_q   <= pulse_d;
      dir_out_q <= dir_out_d;
      err_q     <= err_d;
      stable_q  <= stable_d;
    end
  end

  assign step_pulse_o = pulse_q;
  assign dir_out_o    = dir_out_q;
  assign setup_err_o  = err_q;

`ifdef STEPDIR_POSITION_EN
  logic signed [POS_WIDTH-1:0] pos_q;
  logic signed [POS_WIDTH-1:0] pos_d;

  // Two's complement wrap is intended; no saturation.
  always_comb begin
    pos_d = pos_q;
    if (pulse_d) begin
      pos_d = dir_level ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position_o = pos_q;
`endif
endmodule

// File: doc/step_dir_conditioner.md
STEP_DIR_CONDITIONER -- requirements
Module: step_dir_conditioner

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive stable cycles required before a filtered level changes (legal 1..255).
REQ-002 SHALL have parameter DIR_SETUP, default 2: minimum cycles the filtered dir must be stable before a filtered step rise.
REQ-003 SHALL have parameter POS_WIDTH, default 32: width of the signed position counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high: pulses are emitted and counted; low: suppressed.
REQ-007 step_in  input  1  asynchronous external STEP pin.
REQ-008 dir_in  input  1  asynchronous external DIR pin; 1 = forward.
REQ-009 err_clear  input  1  single-cycle clear of setup_err.
REQ-010 step_pulse  output  1  one-cycle pulse per accepted step, feeding the microstepper step input.
REQ-011 dir_out  output  1  direction associated with the current step_pulse; holds between pulses.
REQ-012 setup_err  output  1  sticky flag: a step was accepted inside the DIR_SETUP window.
REQ-013 position  output  POS_WIDTH  signed step count (present only under STEPDIR_POSITION_EN).

Function
REQ-014 step_in and dir_in SHALL each pass through a two-flop synchronizer before any other logic.
REQ-015 Each synchronized input SHALL have its own glitch filter: a counter increments while the synchronized value differs from the filtered level and clears to 0 on any matching cycle.
REQ-016 The filtered level SHALL toggle on the edge where the mismatch has persisted FILTER_LEN consecutive cycles; the counter then clears.
REQ-017 A pulse shorter than FILTER_LEN cycles after synchronization SHALL produce no filtered change.
REQ-018 step_pulse SHALL be high for exactly one cycle, on the edge after the filtered step rises, so latency from a clean step_in rise is FILTER_LEN+3 clocks.
REQ-019 The filtered step falling edge SHALL produce no pulse.
REQ-020 dir_out SHALL update to the filtered dir on the same edge that step_pulse asserts, and SHALL otherwise hold.
REQ-021 A dir-stable counter SHALL saturate at DIR_SETUP and clear on each filtered dir change.
REQ-022 If a step is accepted while that counter is below DIR_SETUP, setup_err SHALL set; the step is still emitted with the new dir.
REQ-023 err_clear SHALL clear setup_err; if a new violation coincides with err_clear, set SHALL win.
REQ-024 When enable is low, step_pulse SHALL stay 0 and position SHALL hold, while the synchronizers and filters keep running.
REQ-025 A filtered rise seen while enable is low SHALL be discarded, not deferred.
REQ-026 Deasserting enable in the cycle of a pending pulse SHALL suppress that pulse.
REQ-027 Filtered dir changing on the same edge as the filtered step rise SHALL use the new dir and SHALL flag setup_err.

Reset
REQ-028 On reset, synchronizer flops, filtered levels and filter counters SHALL be 0 (filtered step low, dir reverse).
REQ-029 On reset: step_pulse=0, dir_out=0, setup_err=0, position=0, dir-stable counter=DIR_SETUP.
REQ-030 Reset asserted mid-filter or mid-pulse SHALL abort it; no pulse is emitted for the aborted step.
REQ-031 A step_in that is already high at reset release SHALL produce a pulse after FILTER_LEN+3 clocks.

Configuration
REQ-032 Macro STEPDIR_POSITION_EN defined: position port present; it adds +1 (dir_out=1) or -1 on each step_pulse edge, registered with the pulse.
REQ-033 position SHALL wrap in two's complement, with no saturation.
REQ-034 Macro STEPDIR_POSITION_EN undefined: the position port and its counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-035 FILTER_LEN=4, dir_in=1 held 10 cycles, then step_in rises and holds 10 cycles -> one step_pulse 7 clocks after the rise, dir_out=1, position=1, setup_err=0.
REQ-036 step_in high for 3 cycles, then low -> no step_pulse and no position change.
REQ-037 dir_in toggles to 0 one cycle before a clean step_in rise -> pulse emitted with dir_out=0, position decrements to -1, setup_err=1; err_clear then drops it to 0.
REQ-038 enable=0 while 5 clean steps are applied -> zero pulses and position held; enable=1 then 3 steps -> exactly 3 pulses.
REQ-039 position preloaded by stepping to 0x7FFFFFFF, one forward step -> position reads 0x80000000.
REQ-040 Reset asserted 2 cycles after a step_in rise -> no pulse; all outputs read 0 on the cycle after reset.
